// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array job arbiter.
package sa_pkg;

  localparam int SA_OP_BYTES  = 16;
  localparam int SA_RES_BYTES = 16;
  localparam int SA_BYTE_W    = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GRANT,
    S_FILL,
    S_START,
    S_STREAM,
    S_WAIT,
    S_CAPTURE,
    S_RETURN,
    S_ABORT,
    S_DONE
  } sa_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after the pointer, cyclically.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req,
  input  logic          update,
  input  logic [IW-1:0] last_idx,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt[cand]    = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

  // Pointer moves just past the requester that was last served.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (update) begin
      ptr <= (last_idx == IW'(N - 1)) ? '0 : last_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sa_job_arbiter.sv
// Shares one 4x4 systolic-array coprocessor between NREQ requesters:
// gather operands, stream them out, capture the result and hand it back.
//
//   state     | meaning
//   S_IDLE    | no job; wait for any req
//   S_GRANT   | pick requester round-robin, clear err
//   S_FILL    | collect 2*OP_BYTES operand bytes from the granted requester
//   S_START   | one-cycle sa_en pulse
//   S_STREAM  | one buffered byte per cycle into the array, no stalls
//   S_WAIT    | wait for sa_ack with timeout
//   S_CAPTURE | collect RES_BYTES result bytes
//   S_RETURN  | hand result bytes back over valid/ready
//   S_ABORT   | timeout ending: done pulse, release grant
//   S_DONE    | normal ending: done pulse, release grant
module sa_job_arbiter
  import sa_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int OP_BYTES    = SA_OP_BYTES,
  parameter int RES_BYTES   = SA_RES_BYTES,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NREQ-1:0]           req,
  output logic [NREQ-1:0]           gnt,
  input  logic [NREQ-1:0]           in_valid,
  input  logic [SA_BYTE_W*NREQ-1:0] in_data,
  output logic [NREQ-1:0]           in_ready,
  output logic                      out_valid,
  output logic [SA_BYTE_W-1:0]      out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [NREQ-1:0]           done,
  output logic                      err,
  output logic                      sa_en,
  output logic [SA_BYTE_W-1:0]      sa_shift_in,
  input  logic [SA_BYTE_W-1:0]      sa_shift_out,
  input  logic                      sa_ack
);

  localparam int JOB_BYTES = 2 * OP_BYTES;
  localparam int CNT_W     = $clog2(JOB_BYTES + 1);
  localparam int BI_W      = $clog2(JOB_BYTES);
  localparam int R_W       = $clog2(RES_BYTES);
  localparam int T_W       = $clog2(ACK_TIMEOUT + 1);
  localparam int IW        = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [CNT_W-1:0] CNT_FILL_LAST  = CNT_W'(JOB_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_STREAM_END = CNT_W'(JOB_BYTES);
  localparam logic [R_W-1:0]   R_LAST         = R_W'(RES_BYTES - 1);
  localparam logic [T_W-1:0]   T_LOAD         = T_W'(ACK_TIMEOUT - 1);

  sa_state_e            state;
  logic [IW-1:0]        g_idx;
  logic [CNT_W-1:0]     cnt;
  logic [R_W-1:0]       r;
  logic [R_W-1:0]       r_nxt;
  logic [T_W-1:0]       tcnt;
  logic [SA_BYTE_W-1:0] op_buf  [JOB_BYTES];
  logic [SA_BYTE_W-1:0] res_buf [RES_BYTES];

  logic [NREQ-1:0]      pick;
  logic [IW-1:0]        pick_idx;
  logic                 rr_update;
  logic                 sel_valid;
  logic [SA_BYTE_W-1:0] sel_data;

  assign rr_update = (state == S_ABORT) || (state == S_DONE);
  assign r_nxt     = r + 1'b1;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .update   (rr_update),
    .last_idx (g_idx),
    .gnt      (pick),
    .gnt_idx  (pick_idx)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (g_idx == IW'(i)) begin
        sel_valid = in_valid[i];
        sel_data  = in_data[i*SA_BYTE_W +: SA_BYTE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      gnt         <= '0;
      g_idx       <= '0;
      in_ready    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      done        <= '0;
      err         <= 1'b0;
      sa_en       <= 1'b0;
      sa_shift_in <= '0;
      cnt         <= '0;
      r           <= '0;
      tcnt        <= '0;
      for (int i = 0; i < JOB_BYTES; i++) op_buf[i] <= '0;
      for (int i = 0; i < RES_BYTES; i++) res_buf[i] <= '0;
    end else begin
      done <= '0;
      case (state)
        S_IDLE: if (|req) state <= S_GRANT;
        S_GRANT: begin
          if (|pick) begin
            gnt      <= pick;
            in_ready <= pick;
            g_idx    <= pick_idx;
            err      <= 1'b0;
            cnt      <= '0;
            state    <= S_FILL;
          end else begin
            state <= S_IDLE;
          end
        end
        S_FILL: begin
          if (sel_valid) begin
            op_buf[cnt[BI_W-1:0]] <= sel_data;
            if (cnt == CNT_FILL_LAST) begin
              in_ready <= '0;
              sa_en    <= 1'b1;
              state    <= S_START;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_START: begin
          sa_en       <= 1'b0;
          sa_shift_in <= op_buf[0];
          cnt         <= CNT_W'(1);
          state       <= S_STREAM;
        end
        // cnt runs one ahead of the byte on sa_shift_in.
        S_STREAM: begin
          if (cnt == CNT_STREAM_END) begin
            sa_shift_in <= '0;
            tcnt        <= T_LOAD;
            state       <= S_WAIT;
          end else begin
            sa_shift_in <= op_buf[cnt[BI_W-1:0]];
            cnt         <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (sa_ack) begin
            res_buf[0] <= sa_shift_out;
            r          <= R_W'(1);
            state      <= S_CAPTURE;
          end else if (tcnt == T_W'(1)) begin
            err   <= 1'b1;
            done  <= gnt;
            gnt   <= '0;
            state <= S_ABORT;
          end else begin
            tcnt <= tcnt - 1'b1;
          end
        end
        S_CAPTURE: begin
          res_buf[r] <= sa_shift_out;
          if (r == R_LAST) begin
            r         <= '0;
            out_valid <= 1'b1;
            out_data  <= res_buf[0];
            out_last  <= 1'b0;
            state     <= S_RETURN;
          end else begin
            r <= r_nxt;
          end
        end
        S_RETURN: begin
          if (out_ready) begin
            if (r == R_LAST) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              done      <= gnt;
              gnt       <= '0;
              state     <= S_DONE;
            end else begin
              r        <= r_nxt;
              out_data <= res_buf[r_nxt];
              out_last <= (r_nxt == R_LAST);
            end
          end
        end
        S_ABORT, S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sa_job_arbiter.md
Name: sa_job_arbiter

Overview:
- Shares the single 4x4 systolic-array coprocessor between NREQ host requesters.
- Round-robin grant; the granted requester's 32 operand bytes (A then B, 16 each) are gathered into a local buffer at the requester's pace.
- The buffered operands are then streamed to the array byte-per-cycle after a one-cycle en pulse.
- The 16 result bytes are captured while ack is high and returned to the same requester over a valid/ready stream.

Parameters:
- NREQ, 2, number of requesters (2..4).
- OP_BYTES, 16, bytes per operand matrix; a job carries 2*OP_BYTES input bytes.
- RES_BYTES, 16, result bytes per job.
- ACK_TIMEOUT, 255, max cycles from last streamed byte to ack rise before abort.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset. Asynchronous, active-low.
- req  in  NREQ  job request per requester, level, held until done.
- gnt  out  NREQ  one-hot grant.
- in_valid  in  NREQ  operand byte valid per requester.
- in_data  in  8*NREQ  operand bytes; requester i uses [8i+7:8i].
- in_ready  out  NREQ  operand accept, only the granted bit may be 1.
- out_valid  out  1  result byte valid, to the granted requester.
- out_data  out  8  result byte.
- out_last  out  1  marks result byte RES_BYTES-1.
- out_ready  in  1  result accept from the granted requester.
- done  out  NREQ  one-cycle pulse on job completion or abort.
- err  out  1  sticky timeout flag; cleared on next grant.
- sa_en  out  1  coprocessor start.
- sa_shift_in  out  8  byte to coprocessor.
- sa_shift_out  in  8  result byte from coprocessor.
- sa_ack  in  1  coprocessor result-valid.

Behaviour:
- Reset (async, rstn=0):
  - state IDLE; all outputs 0.
  - rr pointer = 0; counters and buffers cleared.
- Main sequence (FSM):
  - IDLE -> GRANT when any req=1.
  - GRANT (1 cycle): pick the first set req at or after rr pointer (cyclic). Set gnt one-hot, clear err. Go to FILL.
  - FILL: in_ready[g]=1.
    - Each cycle with in_valid[g]=1 writes in_data into buf[cnt]; cnt++.
    - After byte 2*OP_BYTES-1 -> START. Requester stalls are allowed.
  - START (1 cycle): sa_en=1, sa_shift_in=0 -> STREAM.
  - STREAM: exactly 2*OP_BYTES consecutive cycles, sa_shift_in=buf[k], k=0..31. No stalls. Then -> WAIT.
  - WAIT: tcnt increments each cycle.
    - sa_ack=1 -> CAPTURE; that same cycle samples sa_shift_out as res[0].
    - tcnt reaches ACK_TIMEOUT -> err=1, ABORT.
  - CAPTURE: samples sa_shift_out into res[1..RES_BYTES-1] on consecutive cycles.
    - sa_ack is ignored after the first cycle.
    - After RES_BYTES total -> RETURN.
  - RETURN: out_valid=1, out_data=res[r].
    - Advance r on out_valid & out_ready.
    - out_last=1 when r=RES_BYTES-1.
    - Transfer of the last byte -> DONE.
  - ABORT (1 cycle) and DONE (1 cycle): done[g]=1, gnt=0, rr pointer=(g+1) mod NREQ -> IDLE.
- Grant and request rules:
  - Deasserting req[g] mid-job has no effect; the job always runs to DONE or ABORT.
  - A new grant takes at least 1 IDLE cycle after DONE.
  - Simultaneous requests are resolved round-robin only; no priority.
  - in_valid from non-granted requesters is ignored.
- Latency: START to first result = 1 + 32 + coprocessor delay. Fixed-latency part: 1+32+16 cycles plus the return handshake.
- Widths: cnt 6 bit, r 4 bit, tcnt clog2(ACK_TIMEOUT+1).
- sa_shift_in = 0 outside STREAM; sa_en = 1 only in START.
- Reset mid-job aborts silently; done is not pulsed.

Decomposition:
- Package sa_pkg: state enum (IDLE, GRANT, FILL, START, STREAM, WAIT, CAPTURE, RETURN, ABORT, DONE), constants SA_OP_BYTES=16, SA_RES_BYTES=16, SA_BYTE_W=8.
- Sub-module rr_arbiter (req, rr pointer -> one-hot grant, combinational plus pointer register), reused by later multi-master blocks.

Test Plan:
- Single job: req=01, bytes 1..32 with random in_valid gaps.
  - Expect gnt=01, then sa_en pulse, then sa_shift_in 1..32 on 32 consecutive cycles.
  - Model ack after 10 cycles with bytes 0x40..0x4F; expect out_data 0x40..0x4F, out_last on 0x4F, done=01.
- Contention: req=11 held.
  - Grants alternate 01,10,01 across three jobs.
  - gnt never 11; in_ready only on the granted bit.
- Backpressure: out_ready toggles 1,0,0,1.
  - Result order is preserved; no byte is duplicated or dropped.
  - sa_* are idle during RETURN.
- Timeout: sa_ack never rises.
  - err=1 exactly ACK_TIMEOUT cycles after the last STREAM byte; done pulses; no out_valid.
  - Next grant clears err.
- Reset mid-STREAM: rstn=0 at stream byte 12.
  - All outputs 0 immediately; after release, req=10 is granted first (rr=0, req0 low), and the full job completes correctly.
- Requester drop: req[0] falls during FILL.
  - Job still completes; done=01 is pulsed.
